// File: rtl/sra_iter.sv
// -----------------------------------------------------------------------------
// sra_iter: iterative 32-bit right shifter (logical or arithmetic).
//
// Resolves one shift-amount bit per cycle, in the order 16, 8, 4, 2, 1, over
// a fixed 5-cycle run. This keeps the wide combinational shift stages off the
// ALU critical path. Latency is fixed: accept edge T, stage edges T+1..T+5,
// result valid after T+5, handshake at the earliest at T+6.
//
// Ports:
//   clock      in   1   single clock, rising-edge active
//   reset_n    in   1   synchronous, active-low reset
//   in_valid   in   1   operand offer
//   in_ready   out  1   unit can accept an operand (IDLE)
//   A          in  32   value to shift
//   shamt      in   5   shift amount, 0..31
//   arith      in   1   1 = sign-fill (SRA), 0 = zero-fill (SRL)
//   out_valid  out  1   S holds a finished result (DONE)
//   out_ready  in   1   consumer accepts the result
//   S          out 32   shifted result (registered)
// -----------------------------------------------------------------------------
module sra_iter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [4:0]  shamt,
  input  logic        arith,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] S
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_d;        // data being shifted; also the result register
  logic [4:0]  r_m;        // captured shift amount
  logic        r_f;        // captured fill bit: arith & A[31]
  logic [2:0]  r_k;        // stage index, 0 -> width 16 ... 4 -> width 1
  logic [31:0] w_d_stage;  // r_d after the current stage

  // One stage per cycle: stage K applies width 16 >> K when M[4-K] is set,
  // shifting in copies of the captured fill bit.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_d_stage = r_d;
    case (r_k)
      3'd0: if (r_m[4]) w_d_stage = {{16{r_f}}, r_d[31:16]};
      3'd1: if (r_m[3]) w_d_stage = {{8{r_f}},  r_d[31:8]};
      3'd2: if (r_m[2]) w_d_stage = {{4{r_f}},  r_d[31:4]};
      3'd3: if (r_m[1]) w_d_stage = {{2{r_f}},  r_d[31:2]};
      3'd4: if (r_m[0]) w_d_stage = {r_f,       r_d[31:1]};
      default: ;
    endcase
  end

  // Next-state and handshake outputs. Outputs depend on state only, so
  // in_ready / out_valid never follow an input combinationally.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_k == 3'd4) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_m     <= '0;
      r_f     <= 1'b0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          // Operands are sampled only here; later input changes are ignored.
          if (in_valid) begin
            r_d <= A;
            r_m <= shamt;
            r_f <= arith & A[31];
            r_k <= '0;
          end
        end
        ST_SHIFT: begin
          r_d <= w_d_stage;
          r_k <= r_k + 3'd1;
        end
        default: ;  // DONE: D holds stable under backpressure
      endcase
    end
  end

  assign S = r_d;

endmodule

// File: tb/tb_sra_iter.sv
// -----------------------------------------------------------------------------
// tb_sra_iter: self-checking bench for sra_iter.
// Directed table vectors, hand-written multi-cycle sequences (backpressure,
// operand isolation, mid-operation reset, back-to-back throughput) and random
// operands checked against an arithmetic reference of >>> / >>.
// -----------------------------------------------------------------------------
module tb_sra_iter;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;

  int checks = 0;
  int errors = 0;

  sra_iter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] sh, logic ar);
    if (ar) return $unsigned($signed(a) >>> sh);
    return a >> sh;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation. hold = cycles of out_ready=0 once out_valid rises;
  // scramble = drive random operands every cycle after the accept edge.
  task automatic do_op(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                       input int hold, input bit scramble, output logic [31:0] res);
    int          cyc;
    logic [31:0] s0;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    A = a; shamt = sh; arith = ar; in_valid = 1'b1;
    out_ready = (hold == 0);
    tick();                                   // accept edge T
    in_valid = 1'b0;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (scramble) begin
        A = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
      end
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'd5);
    res = S;
    s0  = S;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("hold_S", S, s0);
    end
    out_ready = 1'b1;
    tick();                                   // output handshake edge
    check("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  logic [31:0] exp_q[$];
  int          acc_cyc[3];
  logic [31:0] ops_a[3];
  logic [4:0]  ops_sh[3];
  logic        ops_ar[3];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; shamt = '0; arith = 1'b0;

    // Reset state
    tick(); tick();
    reset_n = 1'b1;
    check("reset_in_ready",  {31'd0, in_ready},  32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_S", S, 32'h0);

    // Directed vectors
    vecs.push_back('{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{32'h80000000, 5'd31, 1'b0, 32'h00000001});
    vecs.push_back('{32'h12345678, 5'd0,  1'b1, 32'h12345678});
    vecs.push_back('{32'hF0000000, 5'd21, 1'b1, 32'hFFFFFF80});
    vecs.push_back('{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000});
    vecs.push_back('{32'hFFFFFFFF, 5'd1,  1'b0, 32'h7FFFFFFF});
    vecs.push_back('{32'h80000001, 5'd4,  1'b1, 32'hF8000000});
    vecs.push_back('{32'h0000F000, 5'd12, 1'b1, 32'h0000000F});
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].sh, vecs[i].ar, 0, 1'b0, res);
      check($sformatf("vec%0d_S", i), res, vecs[i].exp);
    end

    // Backpressure for 4 cycles plus operand scrambling during SHIFT
    do_op(32'h9ABCDEF0, 5'd7, 1'b1, 4, 1'b1, res);
    check("backpressure_S", res, 32'hFF3579BD);

    // Reset mid-operation at edge T+3
    A = 32'hDEADBEEF; shamt = 5'd3; arith = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();                                   // T
    in_valid = 1'b0;
    tick(); tick();                           // T+1, T+2
    reset_n = 1'b0;
    tick();                                   // T+3
    reset_n = 1'b1;
    check("midreset_in_ready",  {31'd0, in_ready},  32'd1);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_S", S, 32'h0);
    do_op(32'h00000100, 5'd8, 1'b0, 0, 1'b0, res);
    check("after_reset_S", res, 32'h00000001);

    // Back-to-back with in_valid and out_ready held high
    ops_a[0] = 32'hC0000000; ops_sh[0] = 5'd30; ops_ar[0] = 1'b1;
    ops_a[1] = 32'hC0000000; ops_sh[1] = 5'd30; ops_ar[1] = 1'b0;
    ops_a[2] = 32'h0F0F0F0F; ops_sh[2] = 5'd9;  ops_ar[2] = 1'b1;
    begin
      int nacc = 0, nres = 0, cyc = 0;
      A = ops_a[0]; shamt = ops_sh[0]; arith = ops_ar[0];
      in_valid = 1'b1; out_ready = 1'b1;
      while (nres < 3 && cyc < 60) begin
        bit acc, done;
        acc  = in_valid && in_ready;
        done = out_valid && out_ready;
        if (done) begin
          check($sformatf("b2b%0d_S", nres), S, exp_q.pop_front());
          nres++;
        end
        if (acc) begin
          acc_cyc[nacc] = cyc;
          exp_q.push_back(ref_shift(ops_a[nacc], ops_sh[nacc], ops_ar[nacc]));
          nacc++;
        end
        tick();
        cyc++;
        if (acc) begin
          if (nacc < 3) begin
            A = ops_a[nacc]; shamt = ops_sh[nacc]; arith = ops_ar[nacc];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      check("b2b_results", 32'(nres), 32'd3);
      check("b2b_accepts", 32'(nacc), 32'd3);
      if (nacc == 3) begin
        check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
        check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
      end
    end
    in_valid = 1'b0;
    tick();

    // Random operands, both modes, with operand scrambling during SHIFT
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rm;
      ra = $urandom; rs = 5'($urandom); rm = 1'($urandom);
      if (n % 4 == 0) ra[31] = 1'b1;
      do_op(ra, rs, rm, 0, 1'($urandom), res);
      if (res !== ref_shift(ra, rs, rm))
        check($sformatf("rand_a%h_sh%0d_ar%0d", ra, rs, rm), res, ref_shift(ra, rs, rm));
      else
        checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
